// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite descriptor table.
// Descriptor layout: [23:19] id, [18:10] x, [9:0] y.
// Register addresses for the control/status words above the descriptor window.
package sprite_pkg;

    localparam int DESC_W = 24;

    localparam logic [3:0] ADDR_CTRL   = 4'hC;
    localparam logic [3:0] ADDR_STATUS = 4'hD;
    localparam logic [3:0] ADDR_IRQCLR = 4'hE;

    typedef struct packed {
        logic [4:0] id;
        logic [8:0] x;
        logic [9:0] y;
    } sprite_desc_t;

endpackage

// File: rtl/frame_sync.sv
// Vertical-blank entry detector and 8-bit frame counter.
// Latency: vb_edge_o is combinational in the cycle VCOUNT first reaches the blank line.
// No backpressure; frame_count_o updates the cycle after each edge.
module frame_sync #(
    parameter int VBLANK_LINE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vcount_i,
    output logic       vb_edge_o,
    output logic [7:0] frame_count_o
);

    logic       vblank;
    logic       vb_q;
    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;

    assign vblank        = (int'(vcount_i) >= VBLANK_LINE);
    // vb_q resets to 1 so a reset released inside blank does not fake an entry.
    assign vb_edge_o     = vblank & ~vb_q;
    assign frame_cnt_d   = vb_edge_o ? frame_cnt_q + 8'd1 : frame_cnt_q;
    assign frame_count_o = frame_cnt_q;

    // Track previous blank state and count blank entries (wraps at 255).
    always_ff @(posedge clk) begin
        if (reset) begin
            vb_q        <= 1'b1;
            frame_cnt_q <= 8'd0;
        end else begin
            vb_q        <= vblank;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/sprite_attr_table.sv
// Avalon-MM sprite descriptor table: shadow written by software, copied to active at vblank entry.
// Latency: writes take effect at the sampling edge; readdata valid one cycle after read.
// No wait states; commit requests wait for the next vblank entry.
module sprite_attr_table
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 3,
    parameter int VBLANK_LINE = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [3:0]                    address,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    input  logic [9:0]                    VGA_VCOUNT,
    output logic [NUM_SPRITES*DESC_W-1:0] sprite_active,
    output logic [7:0]                    frame_count,
    output logic                          irq
);

    sprite_desc_t shadow_q [NUM_SPRITES];
    sprite_desc_t shadow_d [NUM_SPRITES];
    sprite_desc_t active_q [NUM_SPRITES];
    sprite_desc_t active_d [NUM_SPRITES];
    logic         pending_q, pending_d;
    logic         irq_q, irq_d;
    logic [31:0]  readdata_q, readdata_d;
    logic         vb_edge;
    logic         wr_en, rd_en, commit;

    frame_sync #(
        .VBLANK_LINE(VBLANK_LINE)
    ) u_frame_sync (
        .clk          (clk),
        .reset        (reset),
        .vcount_i     (VGA_VCOUNT),
        .vb_edge_o    (vb_edge),
        .frame_count_o(frame_count)
    );

    assign wr_en  = chipselect & write;
    assign rd_en  = chipselect & read;
    // Uses the registered pending, so a CTRL write in the edge cycle waits a frame.
    assign commit = vb_edge & pending_q;

    // Next-state for tables, flags and read mux.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        pending_d  = pending_q;
        irq_d      = irq_q;
        readdata_d = readdata_q;

        // Commit copies the pre-write shadow; a same-cycle write only lands in shadow.
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (wr_en) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (address == 4'(k)) begin
                    shadow_d[k] = sprite_desc_t'(writedata[DESC_W-1:0]);
                end
            end
            if (address == ADDR_CTRL && writedata[0]) begin
                pending_d = 1'b1;
            end
            if (address == ADDR_IRQCLR) begin
                irq_d = 1'b0;
            end
        end

        // A commit's irq set overrides a same-cycle clear.
        if (commit) begin
            irq_d = 1'b1;
        end

        // Reads observe registered state, so STATUS in the commit cycle is pre-commit.
        if (rd_en) begin
            readdata_d = 32'd0;
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (address == 4'(k)) begin
                    readdata_d = {8'd0, shadow_q[k]};
                end
            end
            if (address == ADDR_STATUS) begin
                readdata_d = {16'd0, frame_count, 6'd0, irq_q, pending_q};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '{default: '0};
            active_q   <= '{default: '0};
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_active
        assign sprite_active[k*DESC_W +: DESC_W] = active_q[k];
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_sprite_attr_table.sv
// Bench for sprite_attr_table: read results checked through a scoreboard queue,
// outputs (active table, irq, frame counter) checked against expected constants.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_sprite_attr_table;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic          write;
    logic          read;
    logic [3:0]    address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [9:0]    VGA_VCOUNT;
    logic [NS*24-1:0] sprite_active;
    logic [7:0]    frame_count;
    logic          irq;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   exp_q[$];
    logic          rd_seen = 1'b0;
    logic [71:0]   exp_act;

    sprite_attr_table #(
        .NUM_SPRITES(NS),
        .VBLANK_LINE(480)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .VGA_VCOUNT   (VGA_VCOUNT),
        .sprite_active(sprite_active),
        .frame_count  (frame_count),
        .irq          (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: a read seen at a rising edge is compared at the following falling edge.
    always @(posedge clk) rd_seen <= chipselect && read && !reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 128'(readdata), 128'hDEAD);
            end else begin
                chk("readdata", 128'(readdata), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic bus_idle();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 4'd0;
        writedata  = 32'd0;
    endtask

    task automatic drive_write(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
    endtask

    task automatic drive_read(input logic [3:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_write(a, d);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        drive_read(a, exp);
        @(negedge clk);
        bus_idle();
    endtask

    // One active-video line then blank entry; returns just after the edge cycle.
    task automatic frame();
        @(negedge clk);
        VGA_VCOUNT = 10'd0;
        @(negedge clk);
        VGA_VCOUNT = 10'd480;
        @(negedge clk);
    endtask

    // Blank entry with a bus write placed in the edge cycle.
    task automatic frame_with_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        VGA_VCOUNT = 10'd0;
        @(negedge clk);
        VGA_VCOUNT = 10'd480;
        drive_write(a, d);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus_idle();
        reset      = 1'b1;
        VGA_VCOUNT = 10'd0;
        exp_act    = 72'd0;
        do_reset();
        @(negedge clk);

        // Reset state
        chk("rst_active", 128'(sprite_active), 128'd0);
        chk("rst_irq", 128'(irq), 128'd0);
        chk("rst_fc", 128'(frame_count), 128'd0);
        chk("rst_rdata", 128'(readdata), 128'd0);
        bus_read(4'hD, 32'd0);
        bus_read(4'h0, 32'd0);

        // Shadow write/readback, active untouched
        bus_write(4'h1, 32'h00A05010);
        bus_read(4'h1, 32'h00A05010);
        chk("no_commit_active", 128'(sprite_active), 128'd0);
        bus_write(4'h0, 32'hFF111111);  // upper byte dropped
        bus_write(4'h2, 32'h00222222);
        bus_read(4'h0, 32'h00111111);

        // Unmapped and write-only addresses read as zero; unmapped write ignored
        bus_write(4'h5, 32'h12345678);
        bus_read(4'h5, 32'd0);
        bus_read(4'hC, 32'd0);
        @(negedge clk);
        chk("rdata_hold", 128'(readdata), 128'd0);

        // Commit at first blank entry
        bus_write(4'hC, 32'd1);
        bus_read(4'hD, 32'h00000001);
        @(negedge clk); VGA_VCOUNT = 10'd479;
        @(negedge clk); VGA_VCOUNT = 10'd480;
        @(negedge clk);
        exp_act = {24'h222222, 24'hA05010, 24'h111111};
        chk("commit1_active", 128'(sprite_active), 128'(exp_act));
        chk("commit1_irq", 128'(irq), 128'd1);
        chk("commit1_fc", 128'(frame_count), 128'd1);
        bus_read(4'hD, 32'h00000102);

        // Lone IRQCLR
        bus_write(4'hE, 32'd0);
        chk("irqclr", 128'(irq), 128'd0);

        // Shadow write in the commit cycle: active gets the old value
        bus_write(4'hC, 32'd1);
        frame_with_write(4'h0, 32'h00123456);
        chk("wr_commit_active", 128'(sprite_active), 128'(exp_act));
        chk("wr_commit_irq", 128'(irq), 128'd1);
        chk("wr_commit_fc", 128'(frame_count), 128'd2);
        bus_read(4'h0, 32'h00123456);

        // IRQCLR in the commit cycle: set wins
        bus_write(4'hC, 32'd1);
        frame_with_write(4'hE, 32'd0);
        exp_act[23:0] = 24'h123456;
        chk("clr_commit_irq", 128'(irq), 128'd1);
        chk("clr_commit_active", 128'(sprite_active), 128'(exp_act));
        chk("clr_commit_fc", 128'(frame_count), 128'd3);
        bus_write(4'hE, 32'd0);
        chk("irqclr2", 128'(irq), 128'd0);

        // CTRL write in the edge cycle with pending=0: deferred to next frame
        bus_write(4'h2, 32'h000ABCDE);
        frame_with_write(4'hC, 32'd1);
        chk("late_ctrl_irq", 128'(irq), 128'd0);
        chk("late_ctrl_active", 128'(sprite_active), 128'(exp_act));
        bus_read(4'hD, 32'h00000401);

        // Next frame commits; STATUS read in the edge cycle sees pre-commit values
        @(negedge clk); VGA_VCOUNT = 10'd0;
        @(negedge clk); VGA_VCOUNT = 10'd480; drive_read(4'hD, 32'h00000401);
        @(negedge clk); bus_idle();
        exp_act[71:48] = 24'h0ABCDE;
        chk("late_commit_active", 128'(sprite_active), 128'(exp_act));
        chk("late_commit_irq", 128'(irq), 128'd1);
        bus_read(4'hD, 32'h00000502);

        // Reset inside blank with a pending request: all discarded, no spurious edge
        bus_write(4'hC, 32'd1);
        @(negedge clk); VGA_VCOUNT = 10'd500;
        do_reset();
        repeat (4) @(negedge clk);
        chk("rst_blank_fc", 128'(frame_count), 128'd0);
        chk("rst_blank_active", 128'(sprite_active), 128'd0);
        chk("rst_blank_irq", 128'(irq), 128'd0);
        bus_read(4'hD, 32'd0);
        frame();
        chk("post_rst_fc", 128'(frame_count), 128'd1);
        chk("post_rst_active", 128'(sprite_active), 128'd0);
        chk("post_rst_irq", 128'(irq), 128'd0);

        // Frame counter wraps after 256 entries
        for (int i = 0; i < 254; i++) frame();
        chk("fc_255", 128'(frame_count), 128'd255);
        frame();
        chk("fc_wrap", 128'(frame_count), 128'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
